i2s_writer: RTL

Serializes 24-bit audio samples onto a standard I2S bus: bit clock, word-select and serial data, with Philips one-bit delay. It is the consumer end of the `audio_data_request`/`audio_data_ack` handshake whose producer is the I2S memory controller. It runs in the `i2s_clock` domain, buffers one sample ahead of the shifter, and reports underrun and channel-misalignment faults.

---
 rtl/i2s_writer_if.sv | 29 ++
 rtl/i2s_writer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/i2s_writer_if.sv
// rtl/i2s_writer_if.sv - sample handshake between the I2S memory controller and the I2S writer
//
// Four-phase request/acknowledge handshake carrying one 24-bit sample and its
// channel bit.
//   audio_data_request : consumer -> producer, asks for the next sample
//   audio_data_ack     : producer -> consumer, audio_data/audio_lr_bit are valid
//   audio_data         : 24-bit two's complement sample
//   audio_lr_bit       : sample channel, 0 = left, 1 = right
// master = producer (memory controller), slave = consumer (i2s_writer).
interface i2s_writer_if;
  logic        audio_data_request;
  logic        audio_data_ack;
  logic [23:0] audio_data;
  logic        audio_lr_bit;

  modport master (
    input  audio_data_request,
    output audio_data_ack,
    output audio_data,
    output audio_lr_bit
  );

  modport slave (
    output audio_data_request,
    input  audio_data_ack,
    input  audio_data,
    input  audio_lr_bit
  );
endinterface

// File: rtl/i2s_writer.sv
// rtl/i2s_writer.sv - 24-bit I2S serializer with one-sample holding buffer
//
// Generates BCLK/LRCLK/SDATA (Philips format, one-bit delay) from the I2S domain
// clock and pulls samples over a four-phase handshake.
//   clk           : I2S domain clock
//   rst           : asynchronous active-low reset
//   enable        : runs the serializer; low holds the bus idle and flushes the buffer
//   clear_status  : one-cycle pulse clearing the sticky flags
//   bus           : sample handshake (slave side)
//   i2s_bclk      : bit clock, CLOCK_DIVISOR clk cycles per half period
//   i2s_lrclk     : word select, 0 = left, 1 = right
//   i2s_data      : serial data, MSB first
//   underrun      : sticky, a slot started with no buffered sample
//   lr_sync_error : sticky, the buffered sample's channel did not match the slot
module i2s_writer #(
  parameter int CLOCK_DIVISOR = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         clear_status,
  i2s_writer_if.slave  bus,
  output logic         i2s_bclk,
  output logic         i2s_lrclk,
  output logic         i2s_data,
  output logic         underrun,
  output logic         lr_sync_error
);

  localparam logic [7:0] DIV_LAST = 8'(CLOCK_DIVISOR - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_LOW
  } state_t;

  // serializer state
  logic [7:0]  r_div;
  logic        r_bclk;
  logic        r_lrclk;
  logic        r_data;
  logic [4:0]  r_bit_cnt;
  logic [23:0] r_shift;

  // holding buffer
  logic        r_buf_valid;
  logic [23:0] r_buf_data;
  logic        r_buf_lr;

  // sticky flags
  logic        r_underrun;
  logic        r_lr_err;

  // handshake FSM
  state_t      r_state;
  state_t      w_state_next;
  logic        w_req;
  logic        w_capture;

  logic        w_div_tc;
  logic        w_fall;
  logic        w_boundary;
  logic        w_slot_lr;
  logic        w_match;
  logic        w_set_underrun;
  logic        w_set_lr_err;

  assign w_div_tc   = (r_div == DIV_LAST);
  // BCLK is about to go 1->0: the only edge on which the serial outputs move
  assign w_fall     = enable & w_div_tc & r_bclk;
  // bit counter wraps 31->0 on this fall, starting a new slot
  assign w_boundary = w_fall & (r_bit_cnt == 5'd31);
  // channel of the slot being started is the toggled LRCLK
  assign w_slot_lr  = ~r_lrclk;
  assign w_match    = r_buf_valid & (r_buf_lr == w_slot_lr);

  assign w_set_underrun = w_boundary & ~r_buf_valid;
  assign w_set_lr_err   = w_boundary & r_buf_valid & (r_buf_lr != w_slot_lr);

  // ---------------------------------------------------------------- serializer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div     <= 8'd0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b1;
      r_data    <= 1'b0;
      r_bit_cnt <= 5'd31;
      r_shift   <= 24'd0;
    end else if (!enable) begin
      r_div     <= 8'd0;
      r_bclk    <= 1'b0;
      r_lrclk   <= 1'b1;
      r_data    <= 1'b0;
      r_bit_cnt <= 5'd31;
      r_shift   <= 24'd0;
    end else begin
      if (w_div_tc) begin
        r_div  <= 8'd0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 8'd1;
      end
      if (w_fall) begin
        r_bit_cnt <= r_bit_cnt + 5'd1;
        if (w_boundary) begin
          // delay bit, then the freshly loaded word starts on the next fall
          r_lrclk <= ~r_lrclk;
          r_data  <= 1'b0;
          r_shift <= w_match ? r_buf_data : 24'd0;
        end else begin
          // after 24 shifts the register is empty, which yields the zero tail
          r_data  <= r_shift[23];
          r_shift <= {r_shift[22:0], 1'b0};
        end
      end
    end
  end

  // ------------------------------------------------------------ holding buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_data  <= 24'd0;
      r_buf_lr    <= 1'b0;
    end else if (!enable) begin
      // a handshake finishing while disabled is accepted but not kept
      r_buf_valid <= 1'b0;
    end else if (w_capture) begin
      r_buf_valid <= 1'b1;
      r_buf_data  <= bus.audio_data;
      r_buf_lr    <= bus.audio_lr_bit;
    end else if (w_boundary && w_match) begin
      // on a channel mismatch the sample stays for the next slot
      r_buf_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------- status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_underrun <= 1'b0;
      r_lr_err   <= 1'b0;
    end else begin
      r_underrun <= w_set_underrun | (r_underrun & ~clear_status);
      r_lr_err   <= w_set_lr_err   | (r_lr_err   & ~clear_status);
    end
  end

  // -------------------------------------------------------------- handshake FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // ack must be low first so a stale ack is never taken as data
        if (enable && !r_buf_valid && !bus.audio_data_ack) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        w_req = 1'b1;
        if (bus.audio_data_ack) begin
          w_capture    = 1'b1;
          w_state_next = ST_WAIT_LOW;
        end
      end
      ST_WAIT_LOW: begin
        if (!bus.audio_data_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.audio_data_request = w_req;

  assign i2s_bclk      = r_bclk;
  assign i2s_lrclk     = r_lrclk;
  assign i2s_data      = r_data;
  assign underrun      = r_underrun;
  assign lr_sync_error = r_lr_err;

endmodule
